// File: rtl/uop_buffer_pkg.sv
// Shared instruction types for the uop fetch path: word/bundle formats,
// buffer geometry and the load FSM state encoding.
package uop_buffer_pkg;

  localparam int UOP_BUF_SIZE = 16;
  localparam int INSTR_W      = 32;
  localparam int ADDR_W       = $clog2(UOP_BUF_SIZE);
  // One bit wider than the address so a completely full buffer is representable.
  localparam int CNT_W        = ADDR_W + 1;

  localparam logic [INSTR_W-1:0] UOP_NOP = 32'h0000_0000;

  typedef logic [INSTR_W-1:0] instr_word_t;

  // The first word of a pair occupies the upper half of the bundle.
  typedef struct packed {
    instr_word_t first;
    instr_word_t second;
  } instruction_bundle;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } load_state_e;

  function automatic instruction_bundle pack_bundle(input instr_word_t first,
                                                    input instr_word_t second);
    instruction_bundle b;
    b.first  = first;
    b.second = second;
    return b;
  endfunction

endpackage

// File: rtl/uop_buffer_if.sv
// Loader stream and fetch read port of the uop buffer, bundled as one interface.
interface uop_buffer_if;
  import uop_buffer_pkg::*;

  logic                    load_start;
  logic                    in_valid;
  logic                    in_ready;
  logic [INSTR_W-1:0]      in_word;
  logic                    in_last;
  logic [ADDR_W-1:0]       uop_addr;
  instruction_bundle       uop;
  logic                    uop_valid;
  logic                    loaded;
  logic [CNT_W-1:0]        num_bundles;
  logic                    overflow;

  modport master (
    output load_start, in_valid, in_word, in_last, uop_addr,
    input  in_ready, uop, uop_valid, loaded, num_bundles, overflow
  );

  modport slave (
    input  load_start, in_valid, in_word, in_last, uop_addr,
    output in_ready, uop, uop_valid, loaded, num_bundles, overflow
  );

endinterface

// File: rtl/uop_pack_fsm.sv
// Load FSM: pairs incoming instruction words into bundles and emits one write
// per bundle at an auto-incrementing, non-wrapping address.
module uop_pack_fsm
  import uop_buffer_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              load_start,
  input  logic              in_valid,
  input  instr_word_t       in_word,
  input  logic              in_last,
  output logic              in_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output instruction_bundle wr_data,
  output logic              clr_valid,
  output logic              loaded,
  output logic [CNT_W-1:0]  num_bundles,
  output logic              overflow
);

  load_state_e      state_r, state_s;
  logic             slot_r, slot_s;
  instr_word_t      pending_r, pending_s;
  logic [CNT_W-1:0] wr_ptr_r, wr_ptr_s;
  logic             overflow_r, overflow_s;
  logic             full_s;

  assign full_s = (wr_ptr_r == CNT_W'(UOP_BUF_SIZE));

  // State, packing and pointer registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= IDLE;
      slot_r     <= 1'b0;
      pending_r  <= '0;
      wr_ptr_r   <= '0;
      overflow_r <= 1'b0;
    end else begin
      state_r    <= state_s;
      slot_r     <= slot_s;
      pending_r  <= pending_s;
      wr_ptr_r   <= wr_ptr_s;
      overflow_r <= overflow_s;
    end
  end

  // Next-state, bundle assembly and write-port control
  always_comb begin
    state_s    = state_r;
    slot_s     = slot_r;
    pending_s  = pending_r;
    wr_ptr_s   = wr_ptr_r;
    overflow_s = overflow_r;
    in_ready   = 1'b0;
    wr_en      = 1'b0;
    wr_data    = pack_bundle(pending_r, in_word);
    clr_valid  = 1'b0;

    if (load_start) begin
      // A restart wins over any word offered in the same cycle.
      state_s    = LOAD;
      slot_s     = 1'b0;
      wr_ptr_s   = '0;
      overflow_s = 1'b0;
      clr_valid  = 1'b1;
    end else begin
      case (state_r)
        IDLE: begin
          state_s = IDLE;
        end
        LOAD: begin
          in_ready = !full_s;
          if (full_s) begin
            if (in_valid) begin
              overflow_s = 1'b1;
              state_s    = DONE;
            end else begin
              state_s = LOAD;
            end
          end else if (in_valid) begin
            if (!slot_r) begin
              pending_s = in_word;
              slot_s    = 1'b1;
              if (in_last) begin
                // Odd-length program: close the bundle with a NOP right away.
                wr_en    = 1'b1;
                wr_data  = pack_bundle(in_word, UOP_NOP);
                wr_ptr_s = wr_ptr_r + CNT_W'(1);
                state_s  = DONE;
              end else begin
                state_s = LOAD;
              end
            end else begin
              wr_en    = 1'b1;
              wr_data  = pack_bundle(pending_r, in_word);
              wr_ptr_s = wr_ptr_r + CNT_W'(1);
              slot_s   = 1'b0;
              if (in_last) begin
                state_s = DONE;
              end else begin
                state_s = LOAD;
              end
            end
          end else begin
            state_s = LOAD;
          end
        end
        DONE: begin
          state_s = DONE;
        end
        default: begin
          state_s = IDLE;
        end
      endcase
    end
  end

  assign wr_addr     = wr_ptr_r[ADDR_W-1:0];
  assign loaded      = (state_r == DONE);
  assign num_bundles = wr_ptr_r;
  assign overflow    = overflow_r;

endmodule

// File: rtl/uop_buffer.sv
// Uop bundle store: packed loader writes on one side, combinational fetch reads
// with per-entry valid bits on the other.
module uop_buffer
  import uop_buffer_pkg::*;
(
  input logic         clk,
  input logic         reset,
  uop_buffer_if.slave bus
);

  instruction_bundle        mem_r [UOP_BUF_SIZE];
  logic [UOP_BUF_SIZE-1:0]  valid_r;

  logic                     wr_en_s;
  logic [ADDR_W-1:0]        wr_addr_s;
  instruction_bundle        wr_data_s;
  logic                     clr_valid_s;

  uop_pack_fsm u_pack (
    .clk         (clk),
    .reset       (reset),
    .load_start  (bus.load_start),
    .in_valid    (bus.in_valid),
    .in_word     (bus.in_word),
    .in_last     (bus.in_last),
    .in_ready    (bus.in_ready),
    .wr_en       (wr_en_s),
    .wr_addr     (wr_addr_s),
    .wr_data     (wr_data_s),
    .clr_valid   (clr_valid_s),
    .loaded      (bus.loaded),
    .num_bundles (bus.num_bundles),
    .overflow    (bus.overflow)
  );

  // Storage and valid bits; a restart only invalidates, the data stays put
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_r <= '0;
      for (int i = 0; i < UOP_BUF_SIZE; i++) begin
        mem_r[i] <= '0;
      end
    end else if (clr_valid_s) begin
      valid_r <= '0;
    end else if (wr_en_s) begin
      mem_r[wr_addr_s]   <= wr_data_s;
      valid_r[wr_addr_s] <= 1'b1;
    end
  end

  // Read returns pre-write contents; a same-cycle write shows up next cycle.
  assign bus.uop       = mem_r[bus.uop_addr];
  assign bus.uop_valid = valid_r[bus.uop_addr];

endmodule
